// File: rtl/ysyx_2022040010_wb_commit.sv
// Writeback/commit stage: registered register-file write port, a circular commit
// queue feeding the difftest harness, and a RUN/HALT machine for ebreak/ecall.
module ysyx_2022040010_wb_commit #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_npc,
   input  logic [ILEN-1:0] in_inst,
   input  logic            in_rf_we,
   input  logic [4:0]      in_rf_waddr,
   input  logic [XLEN-1:0] in_rf_wdata,
   input  logic            in_sp_e,
   input  logic [1:0]      in_sp_bus,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            dbg_valid,
   input  logic            dbg_ready,
   output logic [XLEN-1:0] dbg_pc,
   output logic [XLEN-1:0] dbg_npc,
   output logic [ILEN-1:0] dbg_inst,
   output logic            dbg_we,
   output logic [4:0]      dbg_waddr,
   output logic [XLEN-1:0] dbg_wdata,
   output logic            halted,
   output logic            ecall_req,
   output logic [63:0]     retire_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   // Handshake: an instruction is accepted on a rising edge where in_valid and
   // in_ready are both high; in_ready depends only on rst, state and fill level.
   // The harness pops the head on an edge where dbg_valid and dbg_ready are high.

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_run;
   logic                 w_full;
   logic                 w_accept;
   logic                 w_pop;
   logic                 w_we;
   logic                 w_ebreak;
   logic                 w_ecall;

   logic [PTR_W-1:0]     r_wptr;
   logic [PTR_W-1:0]     r_rptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_rf_we;
   logic [4:0]           r_rf_waddr;
   logic [XLEN-1:0]      r_rf_wdata;
   logic                 r_ecall_req;
   logic [63:0]          r_retire_cnt;

   logic [XLEN-1:0]      r_q_pc    [DEPTH];
   logic [XLEN-1:0]      r_q_npc   [DEPTH];
   logic [ILEN-1:0]      r_q_inst  [DEPTH];
   logic                 r_q_we    [DEPTH];
   logic [4:0]           r_q_waddr [DEPTH];
   logic [XLEN-1:0]      r_q_wdata [DEPTH];

   // Full blocks acceptance even when a pop happens in the same cycle.
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign in_ready = rst & w_run & ~w_full;
   assign w_accept = in_valid & in_ready;
   assign w_pop    = dbg_valid & dbg_ready;
   assign w_we     = in_rf_we & (in_rf_waddr != 5'd0);
   assign w_ebreak = in_sp_e & in_sp_bus[0];
   assign w_ecall  = in_sp_e & in_sp_bus[1] & ~in_sp_bus[0];

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_RUN;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:   if (w_accept && w_ebreak) w_state_nxt = S_HALT;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      w_run  = (r_state == S_RUN);
      halted = (r_state == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= 5'd0;
         r_rf_wdata   <= '0;
         r_ecall_req  <= 1'b0;
         r_retire_cnt <= 64'd0;
      end else begin
         r_rf_we     <= w_accept & w_we;
         r_ecall_req <= w_accept & w_ecall;
         if (w_accept) begin
            r_rf_waddr   <= in_rf_waddr;
            r_rf_wdata   <= in_rf_wdata;
            r_retire_cnt <= r_retire_cnt + 64'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)    r_rptr <= r_rptr + PTR_W'(1);
         if (w_accept && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_accept && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // Storage needs no reset: entries are only observed while dbg_valid is high.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_q_pc[r_wptr]    <= in_pc;
         r_q_npc[r_wptr]   <= in_npc;
         r_q_inst[r_wptr]  <= in_inst;
         r_q_we[r_wptr]    <= w_we;
         r_q_waddr[r_wptr] <= in_rf_waddr;
         r_q_wdata[r_wptr] <= in_rf_wdata;
      end
   end

   assign dbg_valid  = (r_count != '0);
   assign dbg_pc     = r_q_pc[r_rptr];
   assign dbg_npc    = r_q_npc[r_rptr];
   assign dbg_inst   = r_q_inst[r_rptr];
   assign dbg_we     = r_q_we[r_rptr];
   assign dbg_waddr  = r_q_waddr[r_rptr];
   assign dbg_wdata  = r_q_wdata[r_rptr];

   assign rf_we      = r_rf_we;
   assign rf_waddr   = r_rf_waddr;
   assign rf_wdata   = r_rf_wdata;
   assign ecall_req  = r_ecall_req;
   assign retire_cnt = r_retire_cnt;

endmodule

// File: doc/ysyx_2022040010_wb_commit.md
# ysyx_2022040010_wb_commit

Parametrised writeback/commit stage replacing the stall-vector writeback register. It accepts retiring instructions from MEM over a valid/ready handshake and drives a registered register-file write port. It buffers every retired instruction in a DEPTH-entry commit queue for the difftest harness and runs a RUN/HALT state machine that stops the core on `ebreak` and pulses a trap request on `ecall`.

## Interface
- `XLEN`, 64, data/PC width.
- `ILEN`, 32, instruction width.
- `DEPTH`, 4, commit-queue entries; power of two, ≥2.
- `clk` input 1 — single clock, all state on rising edge.
- `rst` input 1 — synchronous, active-low (0 = reset).
- `in_valid` input 1 — MEM offers a retiring instruction.
- `in_ready` output 1 — stage accepts this cycle.
- `in_pc`, `in_npc` input XLEN — PC and next PC of the instruction.
- `in_inst` input ILEN — instruction word.
- `in_rf_we` input 1, `in_rf_waddr` input 5, `in_rf_wdata` input XLEN — register write request.
- `in_sp_e` input 1 — special-op flag.
- `in_sp_bus` input 2 — bit0 ebreak, bit1 ecall; meaningful only with `in_sp_e`.
- `rf_we` output 1, `rf_waddr` output 5, `rf_wdata` output XLEN — register-file write port and ID bypass bus.
- `dbg_valid` output 1 — commit-queue head valid.
- `dbg_ready` input 1 — harness pops head.
- `dbg_pc`, `dbg_npc` output XLEN, `dbg_inst` output ILEN, `dbg_we` output 1, `dbg_waddr` output 5, `dbg_wdata` output XLEN — head entry.
- `halted` output 1 — FSM in HALT.
- `ecall_req` output 1 — one-cycle trap request.
- `retire_cnt` output 64 — count of accepted instructions.

## Operation
- Accept = `in_valid & in_ready` at a rising edge. `in_ready = rst & (state==RUN) & ~q_full`. It is combinational from state and queue count only, never from `dbg_ready`.
- x0 rule: effective `we = in_rf_we & (in_rf_waddr != 0)`. The same value drives both `rf_we` and the queued `dbg_we`.
- RF port: registered. On accept, the port loads `{we, waddr, wdata}`. With no accept, `rf_we` is 0 the next cycle and `rf_waddr`/`rf_wdata` hold their values.
- Commit queue: circular buffer with DEPTH entries. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
  - Push on accept. Pop when `dbg_valid & dbg_ready`.
  - `dbg_*` shows the entry at the read pointer. It is undefined when `dbg_valid`=0, which the bench must not check.
  - Push and pop in the same cycle leave the count unchanged.
- `retire_cnt` increments by 1 per accept and wraps at 2^64.
- FSM states:
  - RUN → HALT when an accepted instruction has `in_sp_e & in_sp_bus[0]`. The ebreak itself is committed: RF write, queue push, count increment.
  - HALT is terminal until reset. In HALT, `in_ready`=0, while the queue still drains and `halted`=1.
  - ecall (`in_sp_e & in_sp_bus[1]`, accepted): `ecall_req`=1 for exactly the next cycle. The FSM stays in RUN, and the instruction commits normally.
  - If both sp bits are set, ebreak wins: go to HALT with no `ecall_req`.
  - With `in_sp_e`=0, `in_sp_bus` is ignored.

## Timing
- Reset (`rst`=0 at an edge):
  - Pointers and count go to 0 and state to RUN.
  - `rf_we`, `rf_waddr`, `rf_wdata` go to 0.
  - `dbg_valid`=0, `halted`=0, `ecall_req`=0, `retire_cnt`=0.
  - `in_ready`=0 while `rst`=0.
  - Reset mid-operation discards queue contents and HALT state in that cycle.
- Latency: accept at edge t → `rf_we`/`ecall_req`/`halted` visible after edge t. The queue head is visible after edge t if the queue was empty; there is no same-cycle bypass from input to `dbg_*`.
- Full: count==DEPTH → `in_ready`=0, even if a pop occurs in the same cycle. Acceptance resumes the cycle after the pop.
- Empty: `dbg_valid`=0, and a pop request is ignored.
- An upstream offer must be held stable until accepted; the stage does not latch an unaccepted offer.

## Test plan
- **Basic retire:** after reset, accept pc=0x80000000, waddr=5, wdata=0x1234, we=1 with `dbg_ready`=1 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `dbg_valid`=1, `dbg_pc`=0x80000000, `retire_cnt`=1.
- **x0 suppression:** accept we=1, waddr=0, wdata=0xFF → `rf_we`=0, `dbg_we`=0, entry still queued, `retire_cnt` increments.
- **Backpressure and wrap:**
  - Hold `dbg_ready`=0 and offer 5 back-to-back instructions (DEPTH=4) → 4 accepted, then `in_ready`=0.
  - Raise `dbg_ready` → entries pop in order of PC, then the 5th is accepted.
  - Run 10 total push/pop pairs and check order across pointer wrap.
- **Simultaneous push/pop at count 2:** count stays 2 and head advances by one entry.
- **ecall:** accept `sp_e`=1, `sp_bus`=2'b10 → `ecall_req` high exactly one cycle, `halted`=0, next offer accepted.
- **ebreak and reset:**
  - Accept `sp_bus`=2'b11 → `halted`=1, no `ecall_req`, ebreak entry queued, `in_ready` stays 0 for 20 cycles while the queue drains.
  - Assert `rst`=0 for one edge → all outputs 0; after release, `in_ready`=1 and `retire_cnt`=0.
